// File: rtl/chip8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// chip8_mem_arbiter
//
// Shares port A of the CHIP-8 main memory between three requesters:
//   - the external game loader (ld_*)
//   - the CPU data unit (dt_*): Fx55/Fx65 bursts, Fx33 BCD, Dxyn sprite reads
//   - the CPU instruction fetch (fe_*), read only
//
// At most one access is issued per cycle. Grants are combinational, so the
// accepted access reaches the memory in the same cycle. Read data comes back
// one cycle later on the shared rdata bus, qualified by the per-requester
// *_rvalid strobe. Writes into the interpreter area (addr < 0x200) are acked
// but never reach the memory; they raise a one-cycle prot_err instead.
//
// Priority, highest first:
//   lock owner (CPU data while dt_lock held), loader, aged fetch,
//   CPU data, fetch.
// While load_active is high only the loader can be granted.
//
// Ports:
//   clk, res_n             clock, asynchronous active-low reset
//   load_active            loader owns the memory
//   ld_req/we/addr/wdata   loader request;   ld_ack, ld_rvalid
//   dt_req/we/lock/addr/wdata  CPU data;     dt_ack, dt_rvalid
//   fe_req/addr            fetch request;    fe_ack, fe_rvalid
//   rdata                  shared read data (= mem_rdata)
//   prot_err               pulse, protected write accepted last cycle
//   mem_en/write/addr/wdata  memory port A command
//   mem_rdata              memory port A registered read data
// ---------------------------------------------------------------------------
module chip8_mem_arbiter #(
    parameter int AGE_MAX = 4
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        load_active,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [11:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        ld_ack,
    output logic        ld_rvalid,
    input  logic        dt_req,
    input  logic        dt_we,
    input  logic        dt_lock,
    input  logic [11:0] dt_addr,
    input  logic [7:0]  dt_wdata,
    output logic        dt_ack,
    output logic        dt_rvalid,
    input  logic        fe_req,
    input  logic [11:0] fe_addr,
    output logic        fe_ack,
    output logic        fe_rvalid,
    output logic [7:0]  rdata,
    output logic        prot_err,
    output logic        mem_en,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [2:0] AGE_MAX_C = 3'(AGE_MAX);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LD   = 2'd1,
        SEL_DT   = 2'd2,
        SEL_FE   = 2'd3
    } sel_e;

    // The interpreter/font area below 0x200 is write protected.
    function automatic logic is_protected(input logic [11:0] addr);
        return (addr[11:9] == 3'b000);
    endfunction

    sel_e        sel_s;
    logic        grant_s;
    logic [11:0] acc_addr_s;
    logic        acc_we_s;
    logic [7:0]  acc_wdata_s;
    logic        prot_hit_s;

    logic        owner_q,     owner_d;
    logic [2:0]  age_q,       age_d;
    logic        ld_rvalid_q, ld_rvalid_d;
    logic        dt_rvalid_q, dt_rvalid_d;
    logic        fe_rvalid_q, fe_rvalid_d;
    logic        prot_err_q,  prot_err_d;
    logic [11:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    // Arbitration: pick at most one requester from requests and registered state.
    always_comb begin
        sel_s = SEL_NONE;
        if (!res_n) begin
            // No grant may escape while reset is held.
            sel_s = SEL_NONE;
        end else if (load_active) begin
            if (ld_req) begin
                sel_s = SEL_LD;
            end else begin
                sel_s = SEL_NONE;
            end
        end else if (owner_q && dt_lock) begin
            // Locked burst: data unit only, even if it pauses its requests.
            if (dt_req) begin
                sel_s = SEL_DT;
            end else begin
                sel_s = SEL_NONE;
            end
        end else if (ld_req) begin
            sel_s = SEL_LD;
        end else if (fe_req && (age_q == AGE_MAX_C)) begin
            sel_s = SEL_FE;
        end else if (dt_req) begin
            sel_s = SEL_DT;
        end else if (fe_req) begin
            sel_s = SEL_FE;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Route the winning requester's command onto the memory port.
    always_comb begin
        acc_addr_s  = 12'h000;
        acc_we_s    = 1'b0;
        acc_wdata_s = 8'h00;
        case (sel_s)
            SEL_LD: begin
                acc_addr_s  = ld_addr;
                acc_we_s    = ld_we;
                acc_wdata_s = ld_wdata;
            end
            SEL_DT: begin
                acc_addr_s  = dt_addr;
                acc_we_s    = dt_we;
                acc_wdata_s = dt_wdata;
            end
            SEL_FE: begin
                acc_addr_s  = fe_addr;
                acc_we_s    = 1'b0;
                acc_wdata_s = 8'h00;
            end
            default: begin
                acc_addr_s  = 12'h000;
                acc_we_s    = 1'b0;
                acc_wdata_s = 8'h00;
            end
        endcase
    end

    assign grant_s    = (sel_s != SEL_NONE);
    assign prot_hit_s = grant_s && acc_we_s && is_protected(acc_addr_s);

    assign ld_ack    = (sel_s == SEL_LD);
    assign dt_ack    = (sel_s == SEL_DT);
    assign fe_ack    = (sel_s == SEL_FE);

    // A protected write is acked but suppressed at the memory.
    assign mem_en    = grant_s && !prot_hit_s;
    assign mem_write = grant_s && acc_we_s && !prot_hit_s;
    // Address/data hold their last value when idle to avoid needless toggling.
    assign mem_addr  = grant_s ? acc_addr_s : mem_addr_q;
    assign mem_wdata = mem_write ? acc_wdata_s : mem_wdata_q;

    assign rdata     = mem_rdata;
    assign ld_rvalid = ld_rvalid_q;
    assign dt_rvalid = dt_rvalid_q;
    assign fe_rvalid = fe_rvalid_q;
    assign prot_err  = prot_err_q;

    // Next-state for lock ownership, fetch age and the response strobes.
    always_comb begin
        owner_d     = owner_q;
        age_d       = age_q;
        ld_rvalid_d = (sel_s == SEL_LD) && !ld_we;
        dt_rvalid_d = (sel_s == SEL_DT) && !dt_we;
        fe_rvalid_d = (sel_s == SEL_FE);
        prot_err_d  = prot_hit_s;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        if (load_active) begin
            owner_d = 1'b0;
        end else if (!dt_lock) begin
            // First cycle with dt_lock low already arbitrates normally.
            owner_d = 1'b0;
        end else if (sel_s == SEL_DT) begin
            owner_d = 1'b1;
        end else begin
            owner_d = owner_q;
        end

        if (load_active || !fe_req || (sel_s == SEL_FE)) begin
            age_d = 3'd0;
        end else if (age_q != AGE_MAX_C) begin
            age_d = age_q + 3'd1;
        end else begin
            age_d = age_q;
        end
    end

    // State registers; reset also drops any read strobe still in flight.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            owner_q     <= 1'b0;
            age_q       <= 3'd0;
            ld_rvalid_q <= 1'b0;
            dt_rvalid_q <= 1'b0;
            fe_rvalid_q <= 1'b0;
            prot_err_q  <= 1'b0;
            mem_addr_q  <= 12'h000;
            mem_wdata_q <= 8'h00;
        end else begin
            owner_q     <= owner_d;
            age_q       <= age_d;
            ld_rvalid_q <= ld_rvalid_d;
            dt_rvalid_q <= dt_rvalid_d;
            fe_rvalid_q <= fe_rvalid_d;
            prot_err_q  <= prot_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed testbench for chip8_mem_arbiter. A tiny memory model returns
// addr[7:0] ^ 0xA2 one cycle after every enabled read.
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        res_n = 1'b1;
    logic        load_active = 1'b0;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [11:0] ld_addr = 12'h000;
    logic [7:0]  ld_wdata = 8'h00;
    logic        ld_ack, ld_rvalid;
    logic        dt_req = 1'b0, dt_we = 1'b0, dt_lock = 1'b0;
    logic [11:0] dt_addr = 12'h000;
    logic [7:0]  dt_wdata = 8'h00;
    logic        dt_ack, dt_rvalid;
    logic        fe_req = 1'b0;
    logic [11:0] fe_addr = 12'h000;
    logic        fe_ack, fe_rvalid;
    logic [7:0]  rdata;
    logic        prot_err;
    logic        mem_en, mem_write;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    chip8_mem_arbiter #(.AGE_MAX(4)) dut (
        .clk(clk), .res_n(res_n), .load_active(load_active),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rvalid(ld_rvalid),
        .dt_req(dt_req), .dt_we(dt_we), .dt_lock(dt_lock), .dt_addr(dt_addr),
        .dt_wdata(dt_wdata), .dt_ack(dt_ack), .dt_rvalid(dt_rvalid),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_rvalid(fe_rvalid),
        .rdata(rdata), .prot_err(prot_err),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read memory model.
    always @(posedge clk) begin
        if (mem_en && !mem_write) begin
            mem_rdata <= mem_addr[7:0] ^ 8'hA2;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        load_active = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0;
        dt_req = 1'b0; dt_we = 1'b0; dt_lock = 1'b0;
        fe_req = 1'b0;
    endtask

    function automatic logic [31:0] acks();
        return 32'({ld_ack, dt_ack, fe_ack});
    endfunction

    initial begin
        // ---------------- reset with all requests high ----------------
        #1 res_n = 1'b0;
        ld_req = 1'b1; dt_req = 1'b1; fe_req = 1'b1;
        ld_addr = 12'h210; dt_addr = 12'h300; fe_addr = 12'h200;
        repeat (3) tick();
        #1;
        check_val("rst_acks", acks(), 32'h0);
        check_val("rst_mem_en", 32'(mem_en), 32'h0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'h000);
        check_val("rst_rvalid", 32'({ld_rvalid, dt_rvalid, fe_rvalid, prot_err}), 32'h0);
        res_n = 1'b1;
        #1;
        check_val("rst_release_ld_ack", acks(), 32'h4);
        tick();
        clr_inputs();
        tick();

        // ---------------- read latency ----------------
        fe_req = 1'b1; fe_addr = 12'h200;
        #1;
        check_val("rd_fe_ack", acks(), 32'h1);
        check_val("rd_mem_cmd", 32'({mem_en, mem_write, mem_addr}), 32'({1'b1, 1'b0, 12'h200}));
        tick();
        fe_req = 1'b0;
        check_val("rd_fe_rvalid", 32'({ld_rvalid, dt_rvalid, fe_rvalid}), 32'h1);
        check_val("rd_rdata", 32'(rdata), 32'hA2);
        tick();
        check_val("rd_rvalid_once", 32'(fe_rvalid), 32'h0);

        // ---------------- aging ----------------
        dt_req = 1'b1; dt_we = 1'b0; dt_addr = 12'h400;
        fe_req = 1'b1; fe_addr = 12'h202;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_val($sformatf("age_cyc%0d", i), acks(), (i == 4) ? 32'h1 : 32'h2);
            tick();
        end
        clr_inputs();
        tick();

        // ---------------- lock burst ----------------
        dt_req = 1'b1; dt_lock = 1'b1; dt_we = 1'b0; dt_addr = 12'h300;
        fe_req = 1'b1; fe_addr = 12'h204;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_val($sformatf("lock_ack%0d", i), acks(), 32'h2);
            check_val($sformatf("lock_addr%0d", i), 32'(mem_addr), 32'h300 + 32'(i));
            tick();
            check_val($sformatf("lock_rd%0d", i), 32'({dt_rvalid, rdata}),
                      32'({1'b1, 8'(i) ^ 8'hA2}));
            if (i == 0) begin
                ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h500;
            end
            dt_addr = dt_addr + 12'h001;
            if (i == 15) begin
                dt_lock = 1'b0; dt_req = 1'b0;
            end
        end
        #1;
        check_val("unlock_ld_ack", acks(), 32'h4);
        tick();
        ld_req = 1'b0;
        #1;
        check_val("aged_fe_after_lock", acks(), 32'h1);
        tick();
        clr_inputs();
        tick();

        // ---------------- protection ----------------
        dt_req = 1'b1; dt_we = 1'b1; dt_addr = 12'h1FF; dt_wdata = 8'h55;
        #1;
        check_val("prot_ack", acks(), 32'h2);
        check_val("prot_mem_en", 32'(mem_en), 32'h0);
        tick();
        check_val("prot_err_pulse", 32'(prot_err), 32'h1);
        dt_addr = 12'h200; dt_wdata = 8'h66;
        #1;
        check_val("wr_cmd", 32'({dt_ack, mem_en, mem_write, mem_addr, mem_wdata}),
                  32'({1'b1, 1'b1, 1'b1, 12'h200, 8'h66}));
        tick();
        check_val("wr_no_prot", 32'({prot_err, dt_rvalid}), 32'h0);
        clr_inputs();
        #1;
        check_val("idle_hold", 32'({mem_en, mem_addr, mem_wdata}), 32'({1'b0, 12'h200, 8'h66}));
        tick();

        // ---------------- loader mode ----------------
        load_active = 1'b1;
        dt_req = 1'b1; dt_we = 1'b0; dt_addr = 12'h300;
        fe_req = 1'b1; fe_addr = 12'h206;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h200; ld_wdata = 8'h10;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val($sformatf("ld_ack%0d", i), acks(), 32'h4);
            check_val($sformatf("ld_wr%0d", i), 32'({mem_en, mem_write, mem_addr, mem_wdata}),
                      32'({1'b1, 1'b1, 12'h200 + 12'(i), 8'h10 + 8'(i)}));
            tick();
            ld_addr = ld_addr + 12'h001;
            ld_wdata = ld_wdata + 8'h01;
        end
        ld_req = 1'b0;
        #1;
        check_val("ld_mode_no_cpu", acks(), 32'h0);
        tick();
        load_active = 1'b0;
        #1;
        // Age held at 0 during load mode, so data beats fetch here.
        check_val("ld_mode_age0", acks(), 32'h2);
        tick();
        clr_inputs();
        tick();

        // ---------------- reset mid-read ----------------
        fe_req = 1'b1; fe_addr = 12'h202;
        #1;
        check_val("mid_rst_ack", acks(), 32'h1);
        #2;
        res_n = 1'b0;
        tick();
        check_val("mid_rst_no_rvalid", 32'(fe_rvalid), 32'h0);
        clr_inputs();
        res_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Single-clock arbiter sharing the CPU memory's A port (8-bit data, 12-bit address, registered read, writes below 0x200 protected) between three requesters: the external game loader, the CPU data unit (Fx55/Fx65, Fx33 BCD, Dxyn sprite reads) and the CPU instruction fetch. It issues at most one access per cycle, returns read data with one-cycle latency, supports a bus lock for multi-byte CPU data bursts, and ages the fetch requester so it cannot starve. It sits between the CPU core and the memory block; port B (video) is untouched.

## Interface
- AGE_MAX, 4: consecutive lost cycles after which fetch is promoted above CPU data.
- clk  in  1  system clock; all state on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- load_active  in  1  loader owns memory; CPU requesters are never granted.
- ld_req / ld_we  in  1 / 1  loader request / write strobe.
- ld_addr / ld_wdata  in  12 / 8  loader address / write data.
- ld_ack / ld_rvalid  out  1 / 1  loader accept / read data valid.
- dt_req / dt_we / dt_lock  in  1 / 1 / 1  CPU data request / write / hold bus after this grant.
- dt_addr / dt_wdata  in  12 / 8  CPU data address / write data.
- dt_ack / dt_rvalid  out  1 / 1  CPU data accept / read valid.
- fe_req / fe_addr  in  1 / 12  fetch request (read only) / address.
- fe_ack / fe_rvalid  out  1 / 1  fetch accept / read valid.
- rdata  out  8  read data, shared; qualified by the *_rvalid strobes.
- prot_err  out  1  one-cycle pulse: accepted write to address < 0x200.
- mem_en / mem_write  out  1 / 1  memory port A enable / write.
- mem_addr / mem_wdata  out  12 / 8  memory address / write data.
- mem_rdata  in  8  memory port A registered read data.

## Operation
- Grant is combinational from current requests and registered state. At most one of ld_ack, dt_ack, fe_ack is high per cycle; an access is transferred in every cycle where req and ack are both high.
- Priority, highest first: (1) lock owner, (2) loader, (3) fetch if age == AGE_MAX, (4) CPU data, (5) fetch.
- load_active high: only the loader may be granted. The lock is cleared and the age is held at 0.
- Lock: when dt is granted with dt_lock = 1, the CPU data unit becomes owner. The owner is served exclusively, including over the loader, while dt_lock stays high. Ownership clears in the first cycle dt_lock is low, so that cycle arbitrates normally. Loader requests pending during the lock wait.
- Age counter (3 bits, saturating at AGE_MAX): increments each cycle fe_req = 1 and fe_ack = 0; clears on fe_ack or when fe_req = 0.
- Accepted read: mem_en = 1, mem_write = 0, mem_addr = the requester's address.
- Accepted write, addr[11:9] != 0: mem_en = 1, mem_write = 1, mem_wdata driven.
- Accepted write, addr[11:9] == 0: ack is still given, mem_en = 0, and prot_err pulses in the next cycle.
- rdata passes mem_rdata through. The *_rvalid strobe for a read accepted in cycle N is registered and high in cycle N+1 only.
- With no grant, mem_en = 0 and mem_addr/mem_wdata hold their last values.
- Reset: all ack/rvalid/prot_err/mem_en/mem_write = 0, mem_addr = 0, mem_wdata = 0, owner = none, age = 0. Reset mid-read suppresses the pending rvalid.

## Timing
- Accept to memory: same cycle (combinational mem_en/addr). Read data latency is 1 cycle; back-to-back reads from any mix of requesters give one rvalid per cycle, in issue order.
- Requesters hold req/addr/we/wdata stable until ack. Dropping req before ack is legal (abandoned, no access).
- Fetch waits at most AGE_MAX+1 cycles behind CPU data when no lock and no loader is present.
- Simultaneous ld_req, dt_req, fe_req with age < AGE_MAX and no lock: loader, then data, then fetch.
- The lock and age registers update on the edge ending the accept cycle.

## Test plan
- Reset: hold res_n low with all reqs high -> no ack, mem_en = 0, rvalid = 0. Release: next cycle ld_ack = 1 if ld_req is high.
- Read latency: fe_req, fe_addr = 0x200, mem returns 0xA2 -> fe_ack in cycle N, mem_addr = 0x200, fe_rvalid and rdata = 0xA2 in N+1.
- Aging: dt_req held continuously, fe_req held -> dt_ack for 4 cycles, fe_ack on the 5th, age returns to 0.
- Lock burst: dt_lock held for 16 reads 0x300–0x30F while ld_req and fe_req are high -> 16 consecutive dt_acks. The cycle after dt_lock drops, ld_ack is given.
- Protection: dt write to 0x1FF, data 0x55 -> dt_ack = 1, mem_en = 0, prot_err pulses in the next cycle. Write to 0x200 -> mem_write = 1, no prot_err.
- Loader mode: load_active = 1 with dt_req/fe_req high for 10 cycles -> no CPU acks, age stays 0. ld writes to 0x200.. are issued one per cycle.
